// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter and its sub-blocks.
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting port at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: one outstanding request at a time, round-robin
// grant, wait counter with timeout completion. dbg_state exposes the FSM state.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_W-1:0]             address,
    output logic [DATA_W-1:0]             write_data,
    input  logic [DATA_W-1:0]             read_data,
    output logic                          read_req,
    output logic                          write_req,
    input  logic                          mem_ack,
    output logic [1:0]                    dbg_state
);
    localparam int               IDX_W    = $clog2(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Handshake: a request moves when req_valid[p] && req_ready[p] on a rising
    // edge; req_ready is only ever raised in IDLE and is one-hot.
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    g_q, g_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 transfer;

    rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign transfer = (state_q == IDLE) && (|arb_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (transfer) state_d = ISSUE;
            ISSUE:   if (mem_ack || (cnt_q == CNT_LAST)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
        unique case (state_q)
            // Gate on rst so nothing is offered while reset is held.
            IDLE:  if (rst) req_ready = arb_gnt;
            ISSUE: begin
                read_req  = !we_q;
                write_req = we_q;
            end
            RESP: begin
                rsp_valid[g_q] = 1'b1;
                rsp_err        = err_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        g_d     = g_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (transfer) begin
                g_d     = arb_idx;
                we_d    = req_we[arb_idx];
                addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
                wdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            ISSUE: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    if (!we_q) rdata_d = read_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    err_d = (cnt_q == CNT_LAST);
                end
            end
            RESP: ptr_d = (g_q == IDX_W'(NUM_PORTS - 1)) ? '0 : g_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            g_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata  = rdata_q;
    assign address    = addr_q;
    assign write_data = wdata_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int NP = 4;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int RW = 1 + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_we = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     address;
    logic [DW-1:0]     write_data;
    logic [DW-1:0]     read_data = '0;
    logic              read_req;
    logic              write_req;
    logic              mem_ack = 1'b0;
    logic [1:0]        dbg_state;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: arbitration pointer, last read word, per-port requests.
    int                m_ptr;
    logic [DW-1:0]     m_rdata;
    logic              p_we[NP];
    logic [AW-1:0]     p_addr[NP];
    logic [DW-1:0]     p_wdata[NP];
    logic [RW-1:0]     exp_q[$];

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .read_req   (read_req),
        .write_req  (write_req),
        .mem_ack    (mem_ack),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NP-1:0] vmask, input int ptr);
        for (int i = 0; i < NP; i++) begin
            if (vmask[(ptr + i) % NP]) return (ptr + i) % NP;
        end
        return 0;
    endfunction

    task automatic drive_ports(input logic [NP-1:0] vmask);
        req_valid = vmask;
        for (int p = 0; p < NP; p++) begin
            req_we[p]              = p_we[p];
            req_addr[p*AW +: AW]   = p_addr[p];
            req_wdata[p*DW +: DW]  = p_wdata[p];
        end
    endtask

    task automatic scramble_ports();
        for (int p = 0; p < NP; p++) begin
            req_we[p]             = 1'($urandom);
            req_addr[p*AW +: AW]  = AW'($urandom);
            req_wdata[p*DW +: DW] = $urandom;
        end
    endtask

    // Entered and left at posedge+1 of an IDLE cycle. ack_at is the ISSUE cycle
    // (1-based) carrying mem_ack; 0 or beyond TO means the memory never answers.
    task automatic txn(input logic [NP-1:0] vmask, input int ack_at,
                       input logic [DW-1:0] rd, input logic late_ack);
        int            g;
        int            n;
        logic          ok;
        logic [NP-1:0] oh;
        logic          e_err;
        logic [DW-1:0] e_rdata;
        drive_ports(vmask);
        g  = pick(vmask, m_ptr);
        oh = '0;
        oh[g] = 1'b1;
        ok = (ack_at >= 1) && (ack_at <= TO);
        n  = ok ? ack_at : TO;
        exp_q.push_back({!ok, (ok && !p_we[g]) ? rd : m_rdata});
        #1;
        chk("req_ready_grant", req_ready, oh);
        for (int k = 1; k <= n; k++) begin
            step();
            scramble_ports();
            mem_ack   = (k == ack_at);
            read_data = (k == ack_at) ? rd : $urandom;
            #1;
            chk("read_req", read_req, !p_we[g]);
            chk("write_req", write_req, p_we[g]);
            chk("address", address, p_addr[g]);
            chk("write_data", write_data, p_wdata[g]);
            chk("ready_busy", req_ready, 0);
            if (k == 1) chk("state_issue", dbg_state, ISSUE);
        end
        step();
        mem_ack   = late_ack;
        read_data = $urandom;
        #1;
        {e_err, e_rdata} = exp_q.pop_front();
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("strobes_off", {read_req, write_req}, 0);
        chk("ready_resp", req_ready, 0);
        m_ptr   = (g + 1) % NP;
        m_rdata = e_rdata;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic idle_ack(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) begin
            mem_ack   = 1'b1;
            read_data = $urandom;
            #1;
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_strobes", {read_req, write_req}, 0);
            chk("idle_rdata_kept", rsp_rdata, m_rdata);
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_we[p]    = we;
        p_addr[p]  = a;
        p_wdata[p] = d;
    endtask

    initial begin
        m_ptr   = 0;
        m_rdata = '0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p * 16), DW'(p));

        // Reset: outputs quiet even with requests pending.
        req_valid = '1;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_strobes", {read_req, write_req}, 0);
        chk("rst_address", address, 0);
        chk("rst_write_data", write_data, 0);
        step();
        step();
        rst = 1'b1;

        // Single read with ack on the third strobe cycle, right out of reset.
        set_port(0, 1'b0, 27'h100, 32'h0);
        txn(4'b0001, 3, 32'hDEADBEEF, 1'b0);

        // Write to top address; rsp_rdata must keep the previous read word.
        set_port(1, 1'b1, 27'h7FFFFFF, 32'h55AA);
        txn(4'b0010, 2, 32'h12345678, 1'b0);
        idle_ack(2);

        // Two ports held valid continuously alternate, at minimum latency.
        set_port(0, 1'b0, 27'h200, 32'h1);
        set_port(1, 1'b1, 27'h300, 32'hCAFE);
        for (int r = 0; r < 4; r++) txn(4'b0011, 1, $urandom, 1'b0);

        // Timeout with a late ack in RESP, ack exactly on the last cycle, then normal.
        txn(4'b0001, 0, 32'hBAD0BAD0, 1'b1);
        txn(4'b0010, TO, 32'h0, 1'b0);
        set_port(2, 1'b0, 27'h400, 32'h0);
        txn(4'b0100, 2, 32'hA5A5A5A5, 1'b0);

        // Pointer at 3, ports 0 and 2 valid: wrap to port 0.
        txn(4'b0101, 1, 32'h0BADF00D, 1'b0);

        // A request withdrawn before the edge is never taken.
        drive_ports(4'b0100);
        #1;
        chk("cancel_ready", req_ready, 4'b0100);
        req_valid = '0;
        #1;
        chk("cancel_ready_drop", req_ready, 0);
        step();
        chk("cancel_state", dbg_state, IDLE);

        // Leave ptr at 1, then reset during port 1's ISSUE.
        txn(4'b0001, 2, 32'h11112222, 1'b0);
        set_port(1, 1'b0, 27'h555, 32'h0);
        drive_ports(4'b0010);
        step();
        req_valid = '0;
        #1;
        chk("pre_rst_read_req", read_req, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_strobes", {read_req, write_req}, 0);
        chk("async_rst_address", address, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            mem_ack = 1'b1;
            #1;
            chk("in_rst_rsp_valid", rsp_valid, 0);
        end
        step();
        mem_ack = 1'b0;
        rst     = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
        #1;
        chk("post_rst_rsp_valid", rsp_valid, 0);
        step();
        txn(4'b0101, 1, 32'h77778888, 1'b0);

        // Randomized traffic against the model.
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < NP; p++) set_port(p, 1'($urandom), AW'($urandom), $urandom);
            txn(NP'($urandom_range(1, (1 << NP) - 1)), $urandom_range(0, TO + 1),
                $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_ack($urandom_range(1, 2));
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesters (e.g. instruction fetch, data); legal range 2..8.
REQ-002 Parameter ADDR_W, default 27, memory word-address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter TIMEOUT, default 255, maximum wait cycles for mem_ack; legal range 1..65535.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NUM_PORTS  per-port request pending.
REQ-008 req_we  in  NUM_PORTS  per-port write (1) / read (0).
REQ-009 req_addr  in  NUM_PORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  NUM_PORTS*DATA_W  per-port write data, packed like req_addr.
REQ-011 req_ready  out  NUM_PORTS  one-hot accept; a request transfers when req_valid[p] and req_ready[p] are both high.
REQ-012 rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid; shared across ports.
REQ-014 rsp_err  out  1  completion by timeout, valid with rsp_valid.
REQ-015 address  out  ADDR_W  memory address.
REQ-016 write_data  out  DATA_W  memory write data.
REQ-017 read_data  in  DATA_W  memory read data, sampled on mem_ack.
REQ-018 read_req / write_req  out  1 each  memory strobes; never both high.
REQ-019 mem_ack  in  1  memory completion, single-cycle.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; exactly one state at all times.
REQ-021 IDLE: req_ready is combinational, asserted only for the highest-priority port with req_valid high; all other bits are 0.
REQ-022 Priority is round-robin: search starts at ptr and wraps modulo NUM_PORTS; ptr resets to 0.
REQ-023 On transfer in IDLE: latch port index g, we, addr, wdata; go to ISSUE next cycle.
REQ-024 ISSUE: drive address/write_data from latched values; assert write_req if we, else read_req, every cycle until exit.
REQ-025 ISSUE exit on mem_ack: capture read_data (reads only; writes keep the previous rsp_rdata); deassert strobes next cycle; go to RESP.
REQ-026 Wait counter clears on ISSUE entry and increments each ISSUE cycle without mem_ack; on reaching TIMEOUT, exit to RESP with error flag set.
REQ-027 mem_ack in the same cycle the counter reaches TIMEOUT counts as success: rsp_err=0.
REQ-028 RESP: rsp_valid[g]=1 and rsp_err=flag for exactly one cycle; ptr <= (g+1) mod NUM_PORTS; return to IDLE; req_ready stays 0.
REQ-029 mem_ack outside ISSUE is ignored.
REQ-030 A port deasserting req_valid before transfer loses nothing; arbitration is re-evaluated every IDLE cycle.
REQ-031 Minimum latency for a read: transfer cycle T, strobe high T+1, ack at T+1 gives rsp_valid at T+2. Back-to-back throughput is one request per 3 cycles.
REQ-032 The inputs of the owning port are don't-care after transfer.

Reset
REQ-033 While rst is low: state=IDLE, ptr=0, counter=0, flag=0, all latched registers=0.
REQ-034 While rst is low: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, read_req=0, write_req=0, address=0, write_data=0.
REQ-035 Reset asserted mid-ISSUE drops the strobes immediately (asynchronously), and no rsp_valid is ever produced for that request.
REQ-036 First transfer is possible in the first rising edge after rst deasserts.

Structure
REQ-037 Shared package mem_pkg holds the FSM state enum (IDLE, ISSUE, RESP) and the default ADDR_W and DATA_W constants.
REQ-038 One sub-module rr_arbiter (parameter N; inputs request vector and ptr; output one-hot grant and index).

Verification
REQ-039 Scenario: NUM_PORTS=2, port0 reads 0x100, ack after 3 cycles with read_data=0xDEADBEEF -> read_req high 3 cycles, rsp_valid=01, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 Scenario: ports 0 and 1 held valid continuously -> grants alternate 0,1,0,1 and read_req/write_req never both high.
REQ-041 Scenario: TIMEOUT=4, no ack -> strobe high exactly 4 cycles, then rsp_valid with rsp_err=1; the next request proceeds normally.
REQ-042 Scenario: port1 writes 0x55AA to 0x7FFFFFF -> write_req high, address=0x7FFFFFF, write_data=0x55AA, rsp_valid=10, rsp_rdata unchanged.
REQ-043 Scenario: rst pulled low during ISSUE -> strobes 0 in the same cycle, no rsp_valid, ptr=0 after release.
REQ-044 Scenario: NUM_PORTS=4, ptr=3, ports 0 and 2 valid -> port 0 granted (wrap-around).
